wrom_mac_sequencer: RTL and testbench
=====================================

Name: wrom_mac_sequencer

Overview:
Sequences one pass of a dense layer over the bank of 21-bit weight column ROMs. Drives the shared 9-bit ROM row address in step with an incoming feature stream. Multiplies each feature by every column's weight and accumulates one dot product per column. Presents the NUM_COL results through a valid/ready handshake.
Sits between the feature buffer and the activation stage; the ROMs are combinational and external.

Parameters:
DEPTH, 300, rows per pass (features per dot product); 1..512
NUM_COL, 10, number of weight ROM columns served in parallel
W_W, 21, weight width (signed two's complement)
FEAT_W, 16, feature width (signed)
ACC_W, 48, accumulator width per column (signed); must be >= W_W+FEAT_W+1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a pass when idle
busy  out  1  high from accepted start until result handshake
done  out  1  one-cycle pulse on result handshake
feat_valid  in  1  feature stream valid
feat_ready  out  1  feature stream ready
feat_data  in  FEAT_W  signed feature, row order 0..DEPTH-1
rom_adrs  out  9  shared address to all column ROMs (adrs_clm)
rom_data  in  NUM_COL*W_W  concatenated ROM outputs; column c at bits [c*W_W +: W_W]
res_valid  out  1  results valid
res_ready  in  1  results accepted
res_data  out  NUM_COL*ACC_W  accumulators; column c at bits [c*ACC_W +: ACC_W]

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset: state IDLE, row counter 0, rom_adrs 0, all accumulators 0, busy/done/feat_ready/res_valid 0.
- FSM states: IDLE, RUN, DRAIN, OUT.
- IDLE:
  - start=1 clears all accumulators and the pipeline valids, sets busy, and moves to RUN next cycle.
  - start in any other state is ignored.
- RUN:
  - feat_ready=1; rom_adrs = row counter.
  - On a feature handshake (feat_valid & feat_ready): rom_data is sampled in the same cycle as the current address (combinational ROM).
  - Stage P registers the NUM_COL products feat_data*weight, each W_W+FEAT_W bits signed. The counter then increments.
  - The handshake on row DEPTH-1 moves the FSM to DRAIN; the counter and rom_adrs return to 0.
- Stage A: the cycle after a valid P stage, each accumulator adds its sign-extended product.
- Feature bubbles (feat_valid=0) insert pipeline bubbles; accumulators hold.
- DRAIN: feat_ready=0 for exactly 2 cycles so P and A empty, then the FSM moves to OUT.
- OUT:
  - res_valid=1 and res_data holds stable until res_ready.
  - On the handshake: done pulses for 1 cycle, busy drops, and the FSM returns to IDLE the same edge.
  - res_valid deasserts the next cycle.
  - Accumulators keep their values until the next start.
- Latency: last feature handshake to res_valid = 3 cycles. Minimum pass = DEPTH + 3 cycles + handshake.
- Overflow: without the optional feature, accumulation wraps modulo 2^ACC_W.
- Reset mid-pass: aborts immediately to the reset state; no done and no partial result.
- feat_ready is never high outside RUN; extra features are not consumed.
- rom_adrs never exceeds DEPTH-1.

Optional Feature:
WROM_ACC_SAT_EN
- Defined: each accumulate saturates to +(2^(ACC_W-1)-1) or -2^(ACC_W-1) on signed overflow.
  - A sticky per-pass flag sat_flag (out, 1) is added; it sets on any column saturation and clears on start.
- Undefined: two's-complement wrap, and the sat_flag port is absent.

Decomposition:
- Shared package wrom_pkg:
  - state enum (IDLE/RUN/DRAIN/OUT), ADRS_W=9, W_W=21;
  - column-slice helper functions;
  - saturating-add function, used only under WROM_ACC_SAT_EN.
- One natural sub-module: wrom_mac_lane, one column of multiply register plus accumulator (plus saturation), instantiated NUM_COL times via generate.
- FSM, row counter and handshakes stay in the top.

Test Plan:
1. DEPTH=4, NUM_COL=2, model ROM col0 weight=adrs+1, col1 weight=-(adrs+1); features 1,2,3,4 back-to-back -> res col0=30, col1=-30; res_valid 3 cycles after the 4th handshake; done one pulse.
2. Same config, feat_valid toggling 1/0 every cycle -> identical results 30/-30; rom_adrs sequence 0,1,2,3 advancing only on handshakes, then 0.
3. res_ready held 0 for 5 cycles in OUT -> res_data stable, busy=1; start pulses in OUT ignored; a new start after done clears to fresh results.
4. DEPTH=300, NUM_COL=1, ACC_W=40, weights 2^20-1, features 32767:
   - with WROM_ACC_SAT_EN -> result 2^39-1, sat_flag=1;
   - without -> wrapped value equal to 300*(2^20-1)*32767 mod 2^40, interpreted signed.
5. Assert rst_n low on row 150 -> all outputs 0 immediately (async), no done; the next full pass produces the correct sum.
6. Weight -2^20 times feature -32768 on all rows, DEPTH=2 -> col result +2^36 (sign extension and product width checked).

Source files
------------

// File: rtl/wrom_pkg.sv
// Shared types and helpers for the weight-ROM MAC sequencer.
// Optional build macro: WROM_ACC_SAT_EN (saturating accumulation).
package wrom_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

    localparam int ADRS_W = 9;
    localparam int W_W    = 21;

    // LSB position of column `col` in a bus of `width`-bit column slices
    function automatic int col_lsb(input int col, input int width);
        return col * width;
    endfunction

`ifdef WROM_ACC_SAT_EN
    // Signed add clamped to a `width`-bit range (width <= 63). Operands are
    // already inside that range, so the 64-bit sum itself cannot overflow.
    function automatic longint sat_add(input longint a, input longint b,
                                       input int width, output logic ovf);
        longint sum;
        longint hi;
        longint lo;
        sum = a + b;
        hi  = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo  = -hi - 64'sd1;
        ovf = 1'b0;
        if (sum > hi) begin
            sum = hi;
            ovf = 1'b1;
        end else if (sum < lo) begin
            sum = lo;
            ovf = 1'b1;
        end
        return sum;
    endfunction
`endif

endpackage

// File: rtl/wrom_mac_lane.sv
// One weight column: product register (stage P) feeding an accumulator
// (stage A). With WROM_ACC_SAT_EN the accumulator clamps instead of wrapping.
module wrom_mac_lane
    import wrom_pkg::*;
#(
    parameter int W_W    = 21,
    parameter int FEAT_W = 16,
    parameter int ACC_W  = 48
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     load,
    input  logic                     accum,
    input  logic signed [FEAT_W-1:0] feat,
    input  logic signed [W_W-1:0]    weight,
    output logic signed [ACC_W-1:0]  acc
`ifdef WROM_ACC_SAT_EN
    ,
    output logic                     sat
`endif
);

    localparam int PROD_W = W_W + FEAT_W;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc_nxt;

    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

`ifdef WROM_ACC_SAT_EN
    logic signed [63:0] sum_sat;
    logic               ovf;

    // Clamped accumulate; a hit is only reported on cycles that really add
    always_comb begin
        ovf     = 1'b0;
        sum_sat = sat_add(64'(acc), 64'(prod_ext), ACC_W, ovf);
        acc_nxt = sum_sat[ACC_W-1:0];
        sat     = accum & ovf;
    end
`else
    // Plain two's-complement accumulate, wraps modulo 2^ACC_W
    always_comb begin
        acc_nxt = acc + prod_ext;
    end
`endif

    // Stage P: capture feature * weight on a feature handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            prod <= '0;
        else if (clr)
            prod <= '0;
        else if (load)
            prod <= PROD_W'(feat) * PROD_W'(weight);
    end

    // Stage A: fold the registered product into the running sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (accum)
            acc <= acc_nxt;
    end

endmodule

// File: rtl/wrom_mac_sequencer.sv
// Dense-layer pass sequencer: walks the shared weight ROM address with the
// feature stream, runs NUM_COL MAC lanes, and hands out the dot products.
// Optional build macro: WROM_ACC_SAT_EN (saturating lanes + sat_flag port).
module wrom_mac_sequencer
    import wrom_pkg::*;
#(
    parameter int DEPTH   = 300,
    parameter int NUM_COL = 10,
    parameter int W_W     = 21,
    parameter int FEAT_W  = 16,
    parameter int ACC_W   = 48
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    input  logic                     feat_valid,
    output logic                     feat_ready,
    input  logic [FEAT_W-1:0]        feat_data,
    output logic [ADRS_W-1:0]        rom_adrs,
    input  logic [NUM_COL*W_W-1:0]   rom_data,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [NUM_COL*ACC_W-1:0] res_data
`ifdef WROM_ACC_SAT_EN
    ,
    output logic                     sat_flag
`endif
);

    state_t              state;
    state_t              state_nxt;
    logic [ADRS_W-1:0]   cnt;
    logic                drain_cnt;
    logic                p_vld;
    logic                hs;
    logic                clr;
    logic                last;

    assign hs       = feat_valid & feat_ready;
    assign clr      = (state == IDLE) & start;
    assign last     = hs & (cnt == ADRS_W'(DEPTH - 1));
    assign rom_adrs = cnt;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state and handshake outputs
    always_comb begin
        state_nxt  = state;
        busy       = (state != IDLE);
        feat_ready = 1'b0;
        res_valid  = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = RUN;
            RUN: begin
                feat_ready = 1'b1;
                if (last) state_nxt = DRAIN;
            end
            DRAIN: if (drain_cnt) state_nxt = OUT;
            OUT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Row counter: advances per accepted feature, wraps to 0 after the last row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (hs)
            cnt <= last ? '0 : cnt + ADRS_W'(1);
    end

    // Two-cycle drain timer so stages P and A empty before results show
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drain_cnt <= 1'b0;
        else
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
    end

    // Stage P valid: one bit per accepted feature, bubbles when none
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            p_vld <= 1'b0;
        else if (clr)
            p_vld <= 1'b0;
        else
            p_vld <= hs;
    end

`ifdef WROM_ACC_SAT_EN
    logic [NUM_COL-1:0] lane_sat;

    // Sticky per-pass saturation flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sat_flag <= 1'b0;
        else if (clr)
            sat_flag <= 1'b0;
        else if (|lane_sat)
            sat_flag <= 1'b1;
    end
`endif

    for (genvar c = 0; c < NUM_COL; c++) begin : g_lane
        wrom_mac_lane #(
            .W_W    (W_W),
            .FEAT_W (FEAT_W),
            .ACC_W  (ACC_W)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr    (clr),
            .load   (hs),
            .accum  (p_vld),
            .feat   (feat_data),
            .weight (rom_data[col_lsb(c, W_W) +: W_W]),
            .acc    (res_data[col_lsb(c, ACC_W) +: ACC_W])
`ifdef WROM_ACC_SAT_EN
            ,
            .sat    (lane_sat[c])
`endif
        );
    end

endmodule

// File: tb/tb_wrom_mac_sequencer.sv
// Directed bench for wrom_mac_sequencer: three configurations side by side
// (DEPTH=4/2 columns, DEPTH=300/ACC_W=40, DEPTH=2 extreme operands).
module tb_wrom_mac_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [2:0]  start;
    logic        feat_valid;
    logic [15:0] feat_data;
    logic        res_ready;
    logic [2:0]  busy, done, feat_ready, res_valid;
    logic [8:0]  rom_adrs [3];
    logic [41:0] rom0;
    logic [20:0] rom1, rom2;
    logic [95:0] res0;
    logic [39:0] res1;
    logic [47:0] res2;
`ifdef WROM_ACC_SAT_EN
    logic [2:0]  sat_flag;
`endif
    int total = 0;
    int bad   = 0;

    // ROM models: col0 = adrs+1, col1 = -(adrs+1); constant weights elsewhere
    logic signed [20:0] w00;
    always_comb begin
        w00  = 21'(rom_adrs[0]) + 21'sd1;
        rom0 = {-w00, w00};
    end
    assign rom1 = 21'h0FFFFF;
    assign rom2 = 21'h100000;

    wrom_mac_sequencer #(.DEPTH(4), .NUM_COL(2)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .feat_valid(feat_valid), .feat_ready(feat_ready[0]), .feat_data(feat_data),
        .rom_adrs(rom_adrs[0]), .rom_data(rom0), .res_valid(res_valid[0]),
        .res_ready(res_ready), .res_data(res0)
`ifdef WROM_ACC_SAT_EN
        , .sat_flag(sat_flag[0])
`endif
    );

    wrom_mac_sequencer #(.DEPTH(300), .NUM_COL(1), .ACC_W(40)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .feat_valid(feat_valid), .feat_ready(feat_ready[1]), .feat_data(feat_data),
        .rom_adrs(rom_adrs[1]), .rom_data(rom1), .res_valid(res_valid[1]),
        .res_ready(res_ready), .res_data(res1)
`ifdef WROM_ACC_SAT_EN
        , .sat_flag(sat_flag[1])
`endif
    );

    wrom_mac_sequencer #(.DEPTH(2), .NUM_COL(1)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .busy(busy[2]), .done(done[2]),
        .feat_valid(feat_valid), .feat_ready(feat_ready[2]), .feat_data(feat_data),
        .rom_adrs(rom_adrs[2]), .rom_data(rom2), .res_valid(res_valid[2]),
        .res_ready(res_ready), .res_data(res2)
`ifdef WROM_ACC_SAT_EN
        , .sat_flag(sat_flag[2])
`endif
    );

    typedef struct {
        string  name;
        int     sel;
        int     gap;
        longint f0;
        longint fstep;
        longint e0;
        longint e1;
        int     sat;
    } vec_t;

    vec_t vt [6];

    task automatic check(input string name, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int depth(input int sel);
        case (sel)
            0:       return 4;
            1:       return 300;
            default: return 2;
        endcase
    endfunction

    function automatic longint col(input int sel, input int c);
        case (sel)
            0:       return (c == 0) ? longint'($signed(res0[47:0])) : longint'($signed(res0[95:48]));
            1:       return longint'($signed(res1));
            default: return longint'($signed(res2));
        endcase
    endfunction

    // Start a pass, stream features (valid high one cycle then `gap` idle),
    // and stop in OUT with the results sampled. Entered and left at negedge.
    task automatic run_pass(input int sel, input int gap, input longint f0,
                            input longint fstep, output longint r0, output longint r1);
        int row;
        int cyc;
        int lat;
        start[sel] = 1'b1;
        @(negedge clk);
        start[sel] = 1'b0;
        check("busy_after_start", longint'(busy[sel]), 1);
        row = 0;
        cyc = 0;
        while (row < depth(sel) && cyc < 4000) begin
            feat_valid = ((cyc % (gap + 1)) == 0);
            feat_data  = 16'(f0 + row * fstep);
            check("rom_adrs", longint'(rom_adrs[sel]), longint'(row));
            if (feat_valid && feat_ready[sel]) row++;
            cyc++;
            @(negedge clk);
        end
        feat_valid = 1'b0;
        lat = 1;
        while (!res_valid[sel] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", longint'(lat), 3);
        check("adrs_back_to_0", longint'(rom_adrs[sel]), 0);
        r0 = col(sel, 0);
        r1 = col(sel, 1);
    endtask

    // Result handshake: done for exactly the handshake cycle, then idle
    task automatic finish_pass(input int sel);
        check("done_before_ready", longint'(done[sel]), 0);
        res_ready = 1'b1;
        #1;
        check("done_pulse", longint'(done[sel]), 1);
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        check("done_cleared", longint'(done[sel]), 0);
        check("res_valid_cleared", longint'(res_valid[sel]), 0);
        check("busy_cleared", longint'(busy[sel]), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        longint r0, r1, p;
        logic [39:0] low;
        int row, cyc;

        // Wrapped expectation for 300 rows of (2^20-1)*32767 in 40 bits
        p   = 64'sd300 * 64'sd1048575 * 64'sd32767;
        low = p[39:0];

        vt[0] = '{"b2b",      0, 0,      1,  1,  30, -30, 0};
        vt[1] = '{"toggle",   0, 1,      1,  1,  30, -30, 0};
        vt[2] = '{"neg",      0, 0,     -5,  0, -50,  50, 0};
        vt[3] = '{"gap2",     0, 2,      7, -3,  10, -10, 0};
        vt[4] = '{"minmax",   2, 0, -32768,  0, 64'sd68719476736, 0, 0};
`ifdef WROM_ACC_SAT_EN
        vt[5] = '{"big_sat",  1, 0,  32767,  0, (64'sd1 <<< 39) - 64'sd1, 0, 1};
`else
        vt[5] = '{"big_wrap", 1, 0,  32767,  0, longint'($signed(low)), 0, 0};
`endif

        rst_n = 1'b0; start = '0; feat_valid = 1'b0; feat_data = '0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy",      longint'(busy[0]), 0);
        check("rst_feat_ready", longint'(feat_ready[0]), 0);
        check("rst_res_valid", longint'(res_valid[0]), 0);
        check("rst_adrs",      longint'(rom_adrs[0]), 0);
        check("rst_res_col0",  col(0, 0), 0);
        check("rst_done",      longint'(done[0]), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_pass(vt[i].sel, vt[i].gap, vt[i].f0, vt[i].fstep, r0, r1);
            check({vt[i].name, "_col0"}, r0, vt[i].e0);
            if (vt[i].sel == 0) check({vt[i].name, "_col1"}, r1, vt[i].e1);
`ifdef WROM_ACC_SAT_EN
            check({vt[i].name, "_sat"}, longint'(sat_flag[vt[i].sel]), longint'(vt[i].sat));
`endif
            finish_pass(vt[i].sel);
        end

        // Hold results in OUT; a start there is ignored
        run_pass(0, 0, 1, 1, r0, r1);
        for (int k = 0; k < 5; k++) begin
            check("hold_valid", longint'(res_valid[0]), 1);
            check("hold_busy",  longint'(busy[0]), 1);
            check("hold_col0",  col(0, 0), 30);
            check("hold_col1",  col(0, 1), -30);
            start[0] = (k == 2);
            @(negedge clk);
        end
        start[0] = 1'b0;
        check("hold_after_start", longint'(res_valid[0]), 1);
        finish_pass(0);
        check("idle_keeps_result", col(0, 0), 30);
        run_pass(0, 0, -5, 0, r0, r1);
        check("fresh_col0", r0, -50);
        check("fresh_col1", r1, 50);
        finish_pass(0);

        // Asynchronous reset in the middle of a long pass
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        row = 0;
        cyc = 0;
        while (row < 150 && cyc < 1000) begin
            feat_valid = 1'b1;
            feat_data  = 16'd1;
            if (feat_ready[1]) row++;
            cyc++;
            @(negedge clk);
        end
        check("pre_rst_adrs", longint'(rom_adrs[1]), 150);
        rst_n = 1'b0;
        #1;
        check("midrst_busy",       longint'(busy[1]), 0);
        check("midrst_feat_ready", longint'(feat_ready[1]), 0);
        check("midrst_adrs",       longint'(rom_adrs[1]), 0);
        check("midrst_res_valid",  longint'(res_valid[1]), 0);
        check("midrst_done",       longint'(done[1]), 0);
        check("midrst_res",        col(1, 0), 0);
        @(negedge clk);
        feat_valid = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("postrst_no_result", longint'(res_valid[1] | done[1]), 0);
            @(negedge clk);
        end
        run_pass(1, 0, 1, 0, r0, r1);
        check("after_rst_sum", r0, 64'sd300 * 64'sd1048575);
`ifdef WROM_ACC_SAT_EN
        check("after_rst_sat", longint'(sat_flag[1]), 0);
`endif
        finish_pass(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
